// File: rtl/spi_dev_pkg.sv
// ============================================================================
// Module : spi_dev_pkg
// Shared state encoding, counter width and id-width helper for spi_dev_mcmd.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package spi_dev_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_dev_mcmd_match.sv
// ============================================================================
// Module : spi_dev_mcmd_match
// Combinational priority comparator: lowest table index whose byte matches.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_dev_mcmd_match
    import spi_dev_pkg::*;
#(
    parameter int                  N_CMD     = 4,
    parameter int                  ID_W      = id_width(N_CMD),
    parameter logic [8*N_CMD-1:0]  CMD_BYTES = '0
) (
    input  logic [7:0]      data_byte,
    output logic            hit,
    output logic [ID_W-1:0] index
);

    // Scan downwards so the lowest matching entry is the last one written.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = N_CMD - 1; i >= 0; i--) begin
            if (CMD_BYTES[8*i +: 8] == data_byte) begin
                hit   = 1'b1;
                index = ID_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_dev_mcmd.sv
// ============================================================================
// Module : spi_dev_mcmd
// Multi-command SPI device decoder. Optional abort pulse: SPI_DEV_MCMD_ABORT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_dev_mcmd
    import spi_dev_pkg::*;
#(
    parameter int                  N_CMD      = 4,
    parameter int                  MAX_LEN    = 4,
    parameter logic [8*N_CMD-1:0]  CMD_BYTES  = '0,
    parameter logic [8*N_CMD-1:0]  CMD_LENS   = '0,
    parameter logic [N_CMD-1:0]    CMD_REPEAT = '0,
    localparam int                 ID_W       = id_width(N_CMD)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             pw_wdata,
    input  logic                   pw_wcmd,
    input  logic                   pw_wstb,
    input  logic                   pw_end,
    output logic [8*MAX_LEN-1:0]   cmd_data,
    output logic [ID_W-1:0]        cmd_id,
    output logic                   cmd_stb,
    output logic                   cmd_abort
);

    state_t               state, state_p, state_n;
    logic [CNT_W-1:0]     cnt, cnt_p, cnt_n, cnt_inc;
    logic [8*MAX_LEN-1:0] data_n, shifted;
    logic [ID_W-1:0]      id_n, hit_idx;
    logic                 stb_n, hit, hit_rpt, cur_rpt;
    logic [7:0]           hit_len, cur_len;

    spi_dev_mcmd_match #(
        .N_CMD     (N_CMD),
        .ID_W      (ID_W),
        .CMD_BYTES (CMD_BYTES)
    ) u_match (
        .data_byte (pw_wdata),
        .hit       (hit),
        .index     (hit_idx)
    );

    generate
        if (MAX_LEN == 1) begin : g_shift_one
            assign shifted = pw_wdata;
        end else begin : g_shift_many
            assign shifted = {cmd_data[8*MAX_LEN-9:0], pw_wdata};
        end
    endgenerate

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        hit_len = '0;
        hit_rpt = 1'b0;
        cur_len = '0;
        cur_rpt = 1'b0;
        for (int i = 0; i < N_CMD; i++) begin
            if (ID_W'(i) == hit_idx) begin
                hit_len = CMD_LENS[8*i +: 8];
                hit_rpt = CMD_REPEAT[i];
            end
            if (ID_W'(i) == cmd_id) begin
                cur_len = CMD_LENS[8*i +: 8];
                cur_rpt = CMD_REPEAT[i];
            end
        end
    end

    // state_p/cnt_p hold the result of byte processing before pw_end overrides it.
    always_comb begin
        state_p = state;
        cnt_p   = cnt;
        data_n  = cmd_data;
        id_n    = cmd_id;
        stb_n   = 1'b0;
        if (pw_wstb && pw_wcmd) begin
            if (hit) begin
                id_n    = hit_idx;
                cnt_p   = '0;
                data_n  = '0;
                state_p = ST_COLLECT;
                if (hit_len == 8'd0) begin
                    stb_n   = 1'b1;
                    state_p = hit_rpt ? ST_IDLE : ST_DISCARD;
                end
            end else begin
                state_p = ST_DISCARD;
            end
        end else if (pw_wstb && state == ST_COLLECT) begin
            data_n = shifted;
            cnt_p  = cnt_inc;
            if (cnt_inc == cur_len) begin
                stb_n = 1'b1;
                if (cur_rpt) begin
                    cnt_p = '0;
                end else begin
                    state_p = ST_DISCARD;
                end
            end
        end
        state_n = pw_end ? ST_IDLE : state_p;
        cnt_n   = pw_end ? '0 : cnt_p;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            cmd_data <= '0;
            cmd_id   <= '0;
            cmd_stb  <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            cmd_data <= data_n;
            cmd_id   <= id_n;
            cmd_stb  <= stb_n;
        end
    end

`ifdef SPI_DEV_MCMD_ABORT_EN
    logic abort_n;

    // Partial command: interrupted by a new command byte, or left open at pw_end.
    always_comb begin
        abort_n = 1'b0;
        if (pw_wstb && pw_wcmd && state == ST_COLLECT && cnt != '0) begin
            abort_n = 1'b1;
        end
        if (pw_end && state_p == ST_COLLECT && cnt_p != '0) begin
            abort_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_abort <= 1'b0;
        end else begin
            cmd_abort <= abort_n;
        end
    end
`else
    assign cmd_abort = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_dev_mcmd.sv
// ============================================================================
// Module : tb_spi_dev_mcmd
// Directed self-checking bench for spi_dev_mcmd.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_spi_dev_mcmd;

    // Entries: 0:10/len3, 1:20/len2, 2:30/len0, 3:40/len3 repeat, 4:50/len6, 5:10/len1
    localparam logic [47:0] CB = {8'h10, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10};
    localparam logic [47:0] CL = {8'd1, 8'd6, 8'd3, 8'd0, 8'd2, 8'd3};
    localparam logic [5:0]  CR = 6'b001000;
`ifdef SPI_DEV_MCMD_ABORT_EN
    localparam int AB = 1;
`else
    localparam int AB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pw_wdata;
    logic        pw_wcmd, pw_wstb, pw_end;
    logic [31:0] cmd_data;
    logic [2:0]  cmd_id;
    logic        cmd_stb, cmd_abort;

    int checks = 0;
    int failures = 0;
    int stb_cnt = 0;
    int abt_cnt = 0;
    logic [31:0] stb_q[$];

    spi_dev_mcmd #(
        .N_CMD      (6),
        .MAX_LEN    (4),
        .CMD_BYTES  (CB),
        .CMD_LENS   (CL),
        .CMD_REPEAT (CR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pw_wdata  (pw_wdata),
        .pw_wcmd   (pw_wcmd),
        .pw_wstb   (pw_wstb),
        .pw_end    (pw_end),
        .cmd_data  (cmd_data),
        .cmd_id    (cmd_id),
        .cmd_stb   (cmd_stb),
        .cmd_abort (cmd_abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_stb === 1'b1) begin
            stb_cnt++;
            stb_q.push_back(cmd_data);
        end
        if (cmd_abort === 1'b1) abt_cnt++;
    end

    task automatic put(input logic [7:0] d, input logic c, input logic e);
        @(negedge clk);
        pw_wdata = d; pw_wcmd = c; pw_wstb = 1'b1; pw_end = e;
        @(negedge clk);
        pw_wstb = 1'b0; pw_wcmd = 1'b0; pw_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic end_txn();
        @(negedge clk);
        pw_end = 1'b1;
        @(negedge clk);
        pw_end = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pw_wdata = '0; pw_wcmd = 1'b0; pw_wstb = 1'b0; pw_end = 1'b0;
        idle(3);
        checks++; if (cmd_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", cmd_data, 32'h0); end
        checks++; if (cmd_id !== 3'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", cmd_id); end
        checks++; if (cmd_stb !== 1'b0) begin failures++; $display("FAIL reset_stb got=%b exp=0", cmd_stb); end
        checks++; if (cmd_abort !== 1'b0) begin failures++; $display("FAIL reset_abort got=%b exp=0", cmd_abort); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_cmd3();
        int s0 = stb_cnt;
        put(8'h10, 1'b1, 1'b0);
        put(8'hAA, 1'b0, 1'b0);
        put(8'hBB, 1'b0, 1'b0);
        checks++; if (cmd_stb !== 1'b0) begin failures++; $display("FAIL cmd3_early_stb got=%b exp=0", cmd_stb); end
        put(8'hCC, 1'b0, 1'b0);
        checks++; if (cmd_stb !== 1'b1) begin failures++; $display("FAIL cmd3_stb_timing got=%b exp=1", cmd_stb); end
        idle(2);
        checks++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL cmd3_stb_count got=%0d exp=1", stb_cnt - s0); end
        checks++; if (cmd_id !== 3'd0) begin failures++; $display("FAIL cmd3_id got=%0d exp=0", cmd_id); end
        checks++; if (cmd_data !== 32'h00AABBCC) begin failures++; $display("FAIL cmd3_data got=%h exp=%h", cmd_data, 32'h00AABBCC); end
        end_txn();
    endtask

    task automatic test_cmd2();
        int s0 = stb_cnt;
        put(8'h20, 1'b1, 1'b0);
        put(8'h11, 1'b0, 1'b0);
        put(8'h22, 1'b0, 1'b0);
        checks++; if (cmd_stb !== 1'b1) begin failures++; $display("FAIL cmd2_stb_timing got=%b exp=1", cmd_stb); end
        put(8'h33, 1'b0, 1'b0);
        idle(2);
        checks++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL cmd2_stb_count got=%0d exp=1", stb_cnt - s0); end
        checks++; if (cmd_id !== 3'd1) begin failures++; $display("FAIL cmd2_id got=%0d exp=1", cmd_id); end
        checks++; if (cmd_data !== 32'h00001122) begin failures++; $display("FAIL cmd2_data got=%h exp=%h", cmd_data, 32'h00001122); end
        end_txn();
    endtask

    task automatic test_repeat();
        int s0 = stb_cnt;
        int q0 = stb_q.size();
        logic [31:0] v;
        put(8'h40, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) put(8'(i), 1'b0, 1'b0);
        idle(2);
        checks++; if (stb_cnt - s0 !== 3) begin failures++; $display("FAIL rpt_stb_count got=%0d exp=3", stb_cnt - s0); end
        v = (stb_q.size() > q0) ? stb_q[q0] : 32'hxxxxxxxx;
        checks++; if (v[23:0] !== 24'h010203) begin failures++; $display("FAIL rpt_data0 got=%h exp=010203", v[23:0]); end
        v = (stb_q.size() > q0 + 1) ? stb_q[q0+1] : 32'hxxxxxxxx;
        checks++; if (v[23:0] !== 24'h040506) begin failures++; $display("FAIL rpt_data1 got=%h exp=040506", v[23:0]); end
        v = (stb_q.size() > q0 + 2) ? stb_q[q0+2] : 32'hxxxxxxxx;
        checks++; if (v[23:0] !== 24'h070809) begin failures++; $display("FAIL rpt_data2 got=%h exp=070809", v[23:0]); end
        checks++; if (cmd_id !== 3'd3) begin failures++; $display("FAIL rpt_id got=%0d exp=3", cmd_id); end
        end_txn();
    endtask

    task automatic test_nomatch();
        int s0 = stb_cnt;
        put(8'h55, 1'b1, 1'b0);
        put(8'h01, 1'b0, 1'b0);
        put(8'h02, 1'b0, 1'b0);
        put(8'h03, 1'b0, 1'b0);
        idle(2);
        checks++; if (stb_cnt - s0 !== 0) begin failures++; $display("FAIL nomatch_stb_count got=%0d exp=0", stb_cnt - s0); end
        checks++; if (cmd_data !== 32'h06070809) begin failures++; $display("FAIL nomatch_data got=%h exp=%h", cmd_data, 32'h06070809); end
        checks++; if (cmd_id !== 3'd3) begin failures++; $display("FAIL nomatch_id got=%0d exp=3", cmd_id); end
        end_txn();
    endtask

    task automatic test_zero_len();
        int s0 = stb_cnt;
        put(8'h30, 1'b1, 1'b0);
        checks++; if (cmd_stb !== 1'b1) begin failures++; $display("FAIL zlen_stb got=%b exp=1", cmd_stb); end
        checks++; if (cmd_data !== 32'h0) begin failures++; $display("FAIL zlen_data got=%h exp=0", cmd_data); end
        checks++; if (cmd_id !== 3'd2) begin failures++; $display("FAIL zlen_id got=%0d exp=2", cmd_id); end
        put(8'h77, 1'b0, 1'b0);
        idle(2);
        checks++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL zlen_stb_count got=%0d exp=1", stb_cnt - s0); end
        checks++; if (cmd_data !== 32'h0) begin failures++; $display("FAIL zlen_ignored_data got=%h exp=0", cmd_data); end
        end_txn();
    endtask

    task automatic test_long();
        int s0 = stb_cnt;
        put(8'h50, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) put(8'(i), 1'b0, 1'b0);
        idle(2);
        checks++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL long_stb_count got=%0d exp=1", stb_cnt - s0); end
        checks++; if (cmd_data !== 32'h03040506) begin failures++; $display("FAIL long_data got=%h exp=%h", cmd_data, 32'h03040506); end
        checks++; if (cmd_id !== 3'd4) begin failures++; $display("FAIL long_id got=%0d exp=4", cmd_id); end
        end_txn();
    endtask

    task automatic test_priority();
        int s0 = stb_cnt;
        put(8'h10, 1'b1, 1'b0);
        put(8'hAA, 1'b0, 1'b0);
        idle(2);
        checks++; if (stb_cnt - s0 !== 0) begin failures++; $display("FAIL prio_early_count got=%0d exp=0", stb_cnt - s0); end
        checks++; if (cmd_id !== 3'd0) begin failures++; $display("FAIL prio_id got=%0d exp=0", cmd_id); end
        put(8'hBB, 1'b0, 1'b0);
        put(8'hCC, 1'b0, 1'b0);
        idle(2);
        checks++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL prio_stb_count got=%0d exp=1", stb_cnt - s0); end
        end_txn();
    endtask

    task automatic test_restart();
        int s0 = stb_cnt;
        int a0 = abt_cnt;
        put(8'h10, 1'b1, 1'b0);
        put(8'hAA, 1'b0, 1'b0);
        put(8'h20, 1'b1, 1'b0);
        put(8'h11, 1'b0, 1'b0);
        put(8'h22, 1'b0, 1'b0);
        idle(2);
        checks++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL restart_stb_count got=%0d exp=1", stb_cnt - s0); end
        checks++; if (cmd_data !== 32'h00001122) begin failures++; $display("FAIL restart_data got=%h exp=%h", cmd_data, 32'h00001122); end
        checks++; if (abt_cnt - a0 !== AB) begin failures++; $display("FAIL restart_abort got=%0d exp=%0d", abt_cnt - a0, AB); end
        end_txn();
    endtask

    task automatic test_end_abort();
        int s0 = stb_cnt;
        int a0 = abt_cnt;
        put(8'h10, 1'b1, 1'b0);
        put(8'hAA, 1'b0, 1'b0);
        end_txn();
        idle(2);
        checks++; if (stb_cnt - s0 !== 0) begin failures++; $display("FAIL end_abort_stb got=%0d exp=0", stb_cnt - s0); end
        checks++; if (abt_cnt - a0 !== AB) begin failures++; $display("FAIL end_abort_count got=%0d exp=%0d", abt_cnt - a0, AB); end
        put(8'h10, 1'b1, 1'b0);
        put(8'hAA, 1'b0, 1'b0);
        put(8'hBB, 1'b0, 1'b0);
        put(8'hCC, 1'b0, 1'b1);
        put(8'hDD, 1'b0, 1'b0);
        idle(2);
        checks++; if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL end_with_byte_stb got=%0d exp=1", stb_cnt - s0); end
        checks++; if (abt_cnt - a0 !== AB) begin failures++; $display("FAIL end_with_byte_abort got=%0d exp=%0d", abt_cnt - a0, AB); end
        checks++; if (cmd_data !== 32'h00AABBCC) begin failures++; $display("FAIL end_with_byte_data got=%h exp=%h", cmd_data, 32'h00AABBCC); end
    endtask

    task automatic test_reset_mid();
        int s0 = stb_cnt;
        int a0 = abt_cnt;
        put(8'h20, 1'b1, 1'b0);
        put(8'h11, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (cmd_data !== 32'h0) begin failures++; $display("FAIL midrst_data got=%h exp=0", cmd_data); end
        checks++; if (cmd_id !== 3'd0) begin failures++; $display("FAIL midrst_id got=%0d exp=0", cmd_id); end
        rst_n = 1'b1;
        put(8'h22, 1'b0, 1'b0);
        put(8'h33, 1'b0, 1'b0);
        idle(2);
        checks++; if (stb_cnt - s0 !== 0) begin failures++; $display("FAIL midrst_stb got=%0d exp=0", stb_cnt - s0); end
        checks++; if (abt_cnt - a0 !== 0) begin failures++; $display("FAIL midrst_abort got=%0d exp=0", abt_cnt - a0); end
        checks++; if (cmd_data !== 32'h0) begin failures++; $display("FAIL midrst_after_data got=%h exp=0", cmd_data); end
    endtask

    initial begin
        test_reset();
        test_cmd3();
        test_cmd2();
        test_repeat();
        test_nomatch();
        test_zero_len();
        test_long();
        test_priority();
        test_restart();
        test_end_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_dev_mcmd.md
SPI_DEV_MCMD -- requirements
Module: spi_dev_mcmd

Interface
REQ-001 SHALL have parameter N_CMD, default 4: number of command table entries, 1..8.
REQ-002 SHALL have parameter MAX_LEN, default 4: data bytes retained in cmd_data, 1..16.
REQ-003 SHALL have parameter CMD_BYTES [8*N_CMD-1:0], default 0: command byte per entry, entry i at [8i+7:8i].
REQ-004 SHALL have parameter CMD_LENS [8*N_CMD-1:0], default 0: data-byte count per entry, 0..255.
REQ-005 SHALL have parameter CMD_REPEAT [N_CMD-1:0], default 0: per-entry repeat mode mask.
REQ-006 SHALL have ports: clk in 1, system clock; rst_n in 1, reset (one clock; synchronous, active-low).
REQ-007 SHALL have ports: pw_wdata in 8, byte from protocol wrapper; pw_wcmd in 1, byte is command byte; pw_wstb in 1, byte strobe; pw_end in 1, transaction end.
REQ-008 SHALL have ports: cmd_data out 8*MAX_LEN, collected data, newest byte in [7:0]; cmd_id out max(1,clog2(N_CMD)), matched entry index; cmd_stb out 1, command complete pulse; cmd_abort out 1, truncated command pulse.

Function
REQ-009 SHALL implement states IDLE, COLLECT, DISCARD.
REQ-010 On pw_wstb&pw_wcmd in any state, SHALL compare pw_wdata to all entries; lowest matching index wins.
REQ-011 On match: cmd_id<=index, byte counter<=0, cmd_data<=0, state<=COLLECT; if matched CMD_LENS=0, cmd_stb SHALL pulse next cycle and state<=(repeat ? IDLE : DISCARD).
REQ-012 On no match: state<=DISCARD; cmd_id, cmd_data unchanged.
REQ-013 In COLLECT, pw_wstb&~pw_wcmd SHALL shift pw_wdata into cmd_data[7:0] (older bytes shift up, bytes beyond MAX_LEN dropped) and increment counter.
REQ-014 When the byte completes CMD_LENS[cmd_id] bytes, cmd_stb SHALL be high exactly one cycle after that pw_wstb; cmd_data and cmd_id valid that cycle and stable until next pw_wstb.
REQ-015 After completion, repeat entry: counter<=0, stay COLLECT, cmd_data not cleared; non-repeat entry: state<=DISCARD.
REQ-016 Data bytes in IDLE or DISCARD SHALL be ignored (no shift, no strobe).
REQ-017 pw_end SHALL force state<=IDLE, counter<=0 the following cycle.
REQ-018 pw_end coincident with pw_wstb: byte SHALL be processed first (may complete and strobe), then IDLE.
REQ-019 Counter SHALL be 8 bits, no wrap: lengths up to 255 supported; CMD_LENS > MAX_LEN keeps last MAX_LEN bytes.
REQ-020 A command byte in COLLECT SHALL restart decoding per REQ-010 without cmd_stb for the interrupted command.

Reset
REQ-021 rst_n low at clk edge SHALL set state IDLE, counter 0, cmd_data 0, cmd_id 0, cmd_stb 0, cmd_abort 0.
REQ-022 Reset mid-COLLECT SHALL discard partial command with no cmd_stb and no cmd_abort.

Configuration
REQ-023 Macro SPI_DEV_MCMD_ABORT_EN defined: cmd_abort SHALL pulse one cycle after pw_end (or a command byte, REQ-020) when in COLLECT with counter between 1 and length-1 after processing any coincident byte.
REQ-024 Macro undefined: cmd_abort SHALL be tied 0 and no abort logic synthesised; all other behaviour identical.

Structure
REQ-025 State encoding constants and counter width SHALL live in shared package spi_dev_pkg.
REQ-026 Priority comparator SHALL be sub-module spi_dev_mcmd_match (inputs byte, CMD_BYTES; outputs hit, index), purely combinational.

Verification
REQ-027 N_CMD=2, CMD_BYTES={8'h20,8'h10}, CMD_LENS={2,3}: cmd 10, data AA BB CC -> one cmd_stb, cmd_id=0, cmd_data[23:0]=AABBCC.
REQ-028 Same config: cmd 20, data 11 22 33 -> cmd_stb once after 22, cmd_id=1, cmd_data[15:0]=1122; byte 33 ignored.
REQ-029 CMD_REPEAT=2'b01: cmd 10, nine data bytes 01..09 -> three cmd_stb, cmd_data[23:0]=010203, 040506, 070809.
REQ-030 ABORT_EN defined: cmd 10, data AA, pw_end -> cmd_abort one pulse, no cmd_stb; pw_end with third byte -> cmd_stb, no abort.
REQ-031 Cmd byte 55 (no match), data 01 02 03 -> no cmd_stb; rst_n low after cmd 10, AA -> all outputs 0, no pulses.
REQ-032 Zero length entry (CMD_LENS=0, byte 30): cmd 30 -> cmd_stb next cycle, cmd_data=0.
